// File: rtl/sos_cascade_sequencer_if.sv
// Bus bundle for the SOS cascade sequencer: sample/stage handshake,
// coefficient configuration port, live coefficient bank and error status.
interface sos_cascade_sequencer_if #(
  parameter int N_STAGES  = 2,
  parameter int COEF_SIZE = 20
);
  localparam int AW = $clog2(N_STAGES) + 3;

  logic                            sample_trig;
  logic [N_STAGES-1:0]             stage_trig;
  logic [N_STAGES-1:0]             stage_done;
  logic                            out_valid;
  logic                            busy;
  logic                            cfg_we;
  logic [AW-1:0]                   cfg_addr;
  logic [COEF_SIZE-1:0]            cfg_data;
  logic                            cfg_commit;
  logic                            commit_pending;
  logic [N_STAGES*6*COEF_SIZE-1:0] coef_active;
  logic                            err_clr;
  logic                            timeout_err;
  logic [15:0]                     overrun_cnt;

  modport master (
    output sample_trig, stage_done, cfg_we, cfg_addr, cfg_data, cfg_commit, err_clr,
    input  stage_trig, out_valid, busy, commit_pending, coef_active, timeout_err, overrun_cnt
  );

  modport slave (
    input  sample_trig, stage_done, cfg_we, cfg_addr, cfg_data, cfg_commit, err_clr,
    output stage_trig, out_valid, busy, commit_pending, coef_active, timeout_err, overrun_cnt
  );
endinterface

// File: rtl/sos_cascade_sequencer.sv
// Sequencer for a cascade of second-order IIR sections: walks one sample
// through every stage in turn, keeps a double-buffered coefficient bank that
// only swaps while idle, and tracks overruns and hung stages.
module sos_cascade_sequencer #(
  parameter int N_STAGES  = 2,
  parameter int COEF_SIZE = 20,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  sos_cascade_sequencer_if.slave bus
);
  localparam int AW     = $clog2(N_STAGES) + 3;
  localparam int KW     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int BANK_W = N_STAGES * 6 * COEF_SIZE;
  localparam logic [COEF_SIZE-1:0] UNITY = COEF_SIZE'(1) << (COEF_SIZE - 2);

  // Pass-through bank: B0 and GAIN at unity, all other taps zero.
  function automatic logic [BANK_W-1:0] default_bank();
    logic [BANK_W-1:0] b;
    b = '0;
    for (int s = 0; s < N_STAGES; s++) begin
      b[(s*6+0)*COEF_SIZE +: COEF_SIZE] = UNITY;
      b[(s*6+5)*COEF_SIZE +: COEF_SIZE] = UNITY;
    end
    return b;
  endfunction

  localparam logic [BANK_W-1:0] RESET_BANK = default_bank();

  typedef enum logic [1:0] {IDLE, TRIG, WAIT, DONE} state_t;

  state_t              state, state_next;
  logic [KW-1:0]       k, k_next;
  logic [TW-1:0]       tcnt, tcnt_next;
  logic                timeout_hit;
  logic [N_STAGES-1:0] stage_trig_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                pending_q;
  logic [BANK_W-1:0]   active_q;
  logic [BANK_W-1:0]   shadow_q;
  logic                timeout_err_q;
  logic [15:0]         overrun_q;

  logic                idle;
  logic                swap;
  logic [AW-1:0]       addr_stage;
  logic [2:0]          addr_index;
  logic                cfg_hit;
  int                  wr_base;

  assign idle       = (state == IDLE);
  // A commit seen while idle swaps at once; otherwise it waits as pending.
  assign swap       = idle && (pending_q || bus.cfg_commit);
  assign addr_stage = bus.cfg_addr >> 3;
  assign addr_index = bus.cfg_addr[2:0];
  assign cfg_hit    = bus.cfg_we && (addr_index < 3'd6) && (int'(addr_stage) < N_STAGES);
  assign wr_base    = (int'(addr_stage) * 6 + int'(addr_index)) * COEF_SIZE;

  // Next-state logic: stage walk, done matching on the current stage only, and hang detection.
  always_comb begin
    state_next  = state;
    k_next      = k;
    tcnt_next   = tcnt;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sample_trig) begin
          k_next     = '0;
          state_next = TRIG;
        end
      end
      TRIG: begin
        tcnt_next  = '0;
        state_next = WAIT;
      end
      WAIT: begin
        tcnt_next = tcnt + TW'(1);
        if (bus.stage_done[k]) begin
          if (int'(k) == N_STAGES - 1) begin
            state_next = DONE;
          end else begin
            k_next     = k + KW'(1);
            state_next = TRIG;
          end
        end else if (int'(tcnt) == TIMEOUT - 1) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered pulse/busy outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      tcnt         <= '0;
      stage_trig_q <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_next;
      k            <= k_next;
      tcnt         <= tcnt_next;
      stage_trig_q <= (state_next == TRIG) ? (N_STAGES'(1) << k_next) : '0;
      out_valid_q  <= (state_next == DONE);
      busy_q       <= (state_next != IDLE);
    end
  end

  // Coefficient banks: the swap copies the shadow as it was before any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q  <= RESET_BANK;
      shadow_q  <= RESET_BANK;
      pending_q <= 1'b0;
    end else begin
      if (swap) begin
        active_q <= shadow_q;
      end
      if (cfg_hit) begin
        shadow_q[wr_base +: COEF_SIZE] <= bus.cfg_data;
      end
      pending_q <= swap ? (pending_q && bus.cfg_commit) : (pending_q || bus.cfg_commit);
    end
  end

  // Sticky error status; a clear beats a same-cycle set or increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
      overrun_q     <= '0;
    end else if (bus.err_clr) begin
      timeout_err_q <= 1'b0;
      overrun_q     <= '0;
    end else begin
      if (timeout_hit) begin
        timeout_err_q <= 1'b1;
      end
      if (bus.sample_trig && !idle && (overrun_q != 16'hFFFF)) begin
        overrun_q <= overrun_q + 16'd1;
      end
    end
  end

  assign bus.stage_trig     = stage_trig_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.busy           = busy_q;
  assign bus.commit_pending = pending_q;
  assign bus.coef_active    = active_q;
  assign bus.timeout_err    = timeout_err_q;
  assign bus.overrun_cnt    = overrun_q;
endmodule

// File: tb/tb_sos_cascade_sequencer.sv
// Self-checking bench for sos_cascade_sequencer with a sample-level reference model.
module tb_sos_cascade_sequencer;
  localparam int N  = 2;
  localparam int CW = 20;
  localparam int TO = 64;
  localparam int NC = N * 6;
  localparam logic [CW-1:0] UNITY = 20'h40000;

  typedef struct {
    logic [3:0]    addr;
    logic [CW-1:0] data;
    int            slot;
    logic [CW-1:0] exp;
  } cfg_vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;

  sos_cascade_sequencer_if #(.N_STAGES(N), .COEF_SIZE(CW)) bus();

  sos_cascade_sequencer #(.N_STAGES(N), .COEF_SIZE(CW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference model: which stage (if any) the sample is in, pulses due this cycle, and bank arrays.
  int            m_cur;
  bit            m_trig, m_valid;
  int            m_wait;
  bit            m_terr;
  int            m_ocnt;
  bit            m_pend;
  logic [CW-1:0] m_act[NC];
  logic [CW-1:0] m_sh[NC];

  task automatic model_reset();
    m_cur = -1; m_trig = 0; m_valid = 0; m_wait = 0;
    m_terr = 0; m_ocnt = 0; m_pend = 0;
    for (int i = 0; i < NC; i++) begin
      m_act[i] = ((i % 6) == 0 || (i % 6) == 5) ? UNITY : '0;
      m_sh[i]  = m_act[i];
    end
  endtask

  task automatic model_step();
    bit idle, n_trig, n_valid, hung, swap;
    int n_cur, n_wait, st, ix;
    idle = (m_cur < 0) && !m_valid;
    n_cur = m_cur; n_wait = m_wait; n_trig = 0; n_valid = 0; hung = 0;
    if (m_valid) n_cur = -1;
    else if (idle) begin
      if (bus.sample_trig) begin n_cur = 0; n_trig = 1; end
    end else if (m_trig) n_wait = 0;
    else if (bus.stage_done[m_cur]) begin
      if (m_cur == N - 1) begin n_cur = -1; n_valid = 1; end
      else begin n_cur = m_cur + 1; n_trig = 1; end
    end else if (m_wait + 1 == TO) begin hung = 1; n_cur = -1; end
    else n_wait = m_wait + 1;

    if (bus.err_clr) begin m_terr = 0; m_ocnt = 0; end
    else begin
      if (hung) m_terr = 1;
      if (bus.sample_trig && !idle && m_ocnt < 65535) m_ocnt++;
    end

    swap = idle && (m_pend || bus.cfg_commit);
    if (swap) m_act = m_sh;
    st = int'(bus.cfg_addr) / 8;
    ix = int'(bus.cfg_addr) % 8;
    if (bus.cfg_we && ix < 6 && st < N) m_sh[st*6+ix] = bus.cfg_data;
    m_pend = swap ? (m_pend && bus.cfg_commit) : (m_pend || bus.cfg_commit);

    m_cur = n_cur; m_trig = n_trig; m_valid = n_valid; m_wait = n_wait;
  endtask

  always @(posedge clk) begin
    if (reset) model_reset();
    else model_step();
  end

  function automatic logic [N-1:0] exp_trig();
    return m_trig ? (N'(1) << m_cur) : '0;
  endfunction

  function automatic logic [NC*CW-1:0] exp_bank();
    logic [NC*CW-1:0] v;
    for (int i = 0; i < NC; i++) v[i*CW +: CW] = m_act[i];
    return v;
  endfunction

  function automatic logic [CW-1:0] slot(input int idx);
    return bus.coef_active[idx*CW +: CW];
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stage_trig", bus.stage_trig, exp_trig());
      check("out_valid", bus.out_valid, m_valid);
      check("busy", bus.busy, !((m_cur < 0) && !m_valid));
      check("commit_pending", bus.commit_pending, m_pend);
      check("timeout_err", bus.timeout_err, m_terr);
      check("overrun_cnt", bus.overrun_cnt, m_ocnt);
      check("coef_active", bus.coef_active, exp_bank());
    end
  end

  // Stage responder: answers each start pulse after a delay, optionally hangs or adds stray done bits.
  int         cd[N];
  bit         resp_rand = 0;
  bit         noise = 0;
  int         resp_delay = 3;
  int         hang_stage = -1;
  logic [N-1:0] done_v, trig_v;

  function automatic int pick_delay(input int s);
    if (s == hang_stage) return 0;
    if (resp_rand) return ($urandom_range(0, 40) == 0) ? 0 : int'($urandom_range(1, 6));
    return resp_delay;
  endfunction

  always @(negedge clk) begin
    done_v = '0;
    for (int s = 0; s < N; s++) begin
      if (cd[s] == 1) done_v[s] = 1'b1;
      if (cd[s] > 0) cd[s]--;
    end
    trig_v = exp_trig();
    for (int s = 0; s < N; s++) if (trig_v[s]) cd[s] = pick_delay(s);
    if (noise) for (int s = 0; s < N; s++) if ($urandom_range(0, 7) == 0) done_v[s] = 1'b1;
    bus.stage_done = done_v;
  end

  task automatic apply_stimulus(input bit samp, input bit we, input logic [3:0] addr,
                                input logic [CW-1:0] data, input bit commit, input bit clr);
    bus.sample_trig = samp;
    bus.cfg_we      = we;
    bus.cfg_addr    = addr;
    bus.cfg_data    = data;
    bus.cfg_commit  = commit;
    bus.err_clr     = clr;
    @(negedge clk);
    bus.sample_trig = 0; bus.cfg_we = 0; bus.cfg_addr = '0;
    bus.cfg_data = '0; bus.cfg_commit = 0; bus.err_clr = 0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < max_cycles) begin
      apply_stimulus(0, 0, '0, '0, 0, 0);
      n++;
    end
    if (n >= max_cycles) check("wait_idle_bound", bus.busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cfg_vec_t tbl[7];
    int s, t0, t1, tv, te, nvalid;

    tbl[0] = '{4'b0_000, 20'h11111, 0,  20'h11111};
    tbl[1] = '{4'b0_101, 20'h22222, 5,  20'h22222};
    tbl[2] = '{4'b1_011, 20'h33333, 9,  20'h33333};
    tbl[3] = '{4'b1_100, 20'h44444, 10, 20'h44444};
    tbl[4] = '{4'b0_110, 20'h55555, 6,  UNITY};
    tbl[5] = '{4'b0_111, 20'h66666, 7,  20'h00000};
    tbl[6] = '{4'b1_101, 20'h77777, 11, 20'h77777};

    bus.sample_trig = 0; bus.cfg_we = 0; bus.cfg_addr = '0;
    bus.cfg_data = '0; bus.cfg_commit = 0; bus.err_clr = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    chk_en = 1;
    reset = 0;

    check("rst_busy", bus.busy, 0);
    check("rst_stage_trig", bus.stage_trig, 0);
    check("rst_overrun", bus.overrun_cnt, 0);
    check("rst_b0_s0", slot(0), UNITY);
    check("rst_a2_s0", slot(4), 0);
    check("rst_gain_s1", slot(11), UNITY);
    apply_stimulus(0, 0, '0, '0, 0, 0);

    // Basic two-stage run, each stage answering 3 cycles after its start.
    s = cyc; t0 = -1; t1 = -1; tv = -1;
    apply_stimulus(1, 0, '0, '0, 0, 0);
    for (int i = 0; i < 40 && tv < 0; i++) begin
      if (bus.stage_trig == 2'b01 && t0 < 0) t0 = cyc;
      if (bus.stage_trig == 2'b10 && t1 < 0) t1 = cyc;
      if (bus.out_valid) tv = cyc;
      apply_stimulus(0, 0, '0, '0, 0, 0);
    end
    check("seq_trig0_lat", t0 - s, 1);
    check("seq_trig1_lat", t1 - s, 5);
    check("seq_valid_lat", tv - s, 9);
    check("seq_busy_after", bus.busy, 0);

    // Overruns at 4 and 6 cycles into a run.
    s = cyc;
    apply_stimulus(1, 0, '0, '0, 0, 0);
    repeat (3) apply_stimulus(0, 0, '0, '0, 0, 0);
    apply_stimulus(1, 0, '0, '0, 0, 0);
    apply_stimulus(0, 0, '0, '0, 0, 0);
    apply_stimulus(1, 0, '0, '0, 0, 0);
    wait_idle(50);
    check("overrun_two", bus.overrun_cnt, 2);
    apply_stimulus(0, 0, '0, '0, 0, 1);
    check("overrun_cleared", bus.overrun_cnt, 0);

    // Stage 1 hangs.
    hang_stage = 1; t1 = -1; te = -1; nvalid = 0;
    apply_stimulus(1, 0, '0, '0, 0, 0);
    for (int i = 0; i < 200 && te < 0; i++) begin
      if (bus.stage_trig == 2'b10 && t1 < 0) t1 = cyc;
      if (bus.out_valid) nvalid++;
      if (bus.timeout_err && te < 0) te = cyc;
      if (te < 0) apply_stimulus(0, 0, '0, '0, 0, 0);
    end
    hang_stage = -1;
    check("timeout_lat", te - t1, TO + 1);
    check("timeout_no_valid", nvalid, 0);
    check("timeout_idle", bus.busy, 0);
    apply_stimulus(1, 0, '0, '0, 0, 0);
    check("timeout_next_accept", bus.stage_trig, 2'b01);
    wait_idle(50);
    apply_stimulus(0, 0, '0, '0, 0, 1);
    check("timeout_cleared", bus.timeout_err, 0);

    // Commit requested while busy waits for the end of the run.
    apply_stimulus(1, 0, '0, '0, 0, 0);
    repeat (2) apply_stimulus(0, 0, '0, '0, 0, 0);
    apply_stimulus(0, 1, 4'b1_011, 20'd524683, 0, 0);
    apply_stimulus(0, 0, '0, '0, 1, 0);
    tv = -1;
    for (int i = 0; i < 40 && tv < 0; i++) begin
      if (bus.out_valid) tv = cyc;
      else apply_stimulus(0, 0, '0, '0, 0, 0);
    end
    check("busy_commit_hold", slot(9), 0);
    check("busy_commit_pend", bus.commit_pending, 1);
    apply_stimulus(0, 0, '0, '0, 0, 0);
    check("busy_commit_hold2", slot(9), 0);
    apply_stimulus(0, 0, '0, '0, 0, 0);
    check("busy_commit_applied", slot(9), 20'd524683);
    check("busy_commit_pend_clr", bus.commit_pending, 0);

    // Commit, sample and a shadow write all in one idle cycle.
    apply_stimulus(0, 1, 4'b0_010, 20'hABCDE, 0, 0);
    apply_stimulus(1, 1, 4'b0_001, 20'h13579, 1, 0);
    check("same_cycle_new_bank", slot(2), 20'hABCDE);
    check("same_cycle_b1_old", slot(1), 0);
    check("same_cycle_started", bus.stage_trig, 2'b01);
    wait_idle(50);
    apply_stimulus(0, 0, '0, '0, 1, 0);
    check("same_cycle_b1_later", slot(1), 20'h13579);

    // Address decode table.
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(0, 1, tbl[i].addr, tbl[i].data, 0, 0);
      apply_stimulus(0, 0, '0, '0, 1, 0);
      check($sformatf("tbl%0d_slot", i), slot(tbl[i].slot), tbl[i].exp);
      check($sformatf("tbl%0d_pending", i), bus.commit_pending, 0);
    end

    // Reset in the middle of a run.
    apply_stimulus(1, 0, '0, '0, 0, 0);
    repeat (5) apply_stimulus(1, 0, '0, '0, 0, 0);
    check("pre_reset_overrun", bus.overrun_cnt, 5);
    check("pre_reset_busy", bus.busy, 1);
    reset = 1;
    apply_stimulus(0, 0, '0, '0, 0, 0);
    reset = 0;
    check("mid_reset_busy", bus.busy, 0);
    check("mid_reset_trig", bus.stage_trig, 0);
    check("mid_reset_overrun", bus.overrun_cnt, 0);
    check("mid_reset_b0_s0", slot(0), UNITY);
    check("mid_reset_a1_s1", slot(9), 0);
    check("mid_reset_gain_s1", slot(11), UNITY);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, '0, '0, 0, 0);
      check("post_reset_quiet", {bus.busy, bus.out_valid, bus.stage_trig}, 0);
    end

    // Randomized traffic against the model.
    resp_rand = 1; noise = 1;
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 4'($urandom),
                     20'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end
    noise = 0; resp_rand = 0;
    wait_idle(200);
    apply_stimulus(0, 0, '0, '0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
